wb_stage: RTL and testbench

- Writeback stage directly upstream of the register file write port.
- Accepts completed instructions from the execute/memory stage over a valid/ready handshake.
- Waits for multi-cycle load data, then sign/zero-extends and aligns it.
- Drives a registered, single-cycle write strobe, address and data into the register file, and exposes the in-flight load destination to the hazard unit.

---
 rtl/wb_stage.sv | 160 ++++++++++++++++
 tb/tb_wb_stage.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: accepts completed instructions, waits for load data, formats it and drives the register file write port.
// Optional retire counter output is enabled by defining WB_RETIRE_COUNT_EN.
module wb_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [4:0]  i_rd,
  input  logic        i_rd_we,
  input  logic        i_is_load,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_alu_result,
  input  logic [31:0] i_mem_rdata,
  input  logic        i_mem_rvalid,
  output logic        o_reg_we,
  output logic [4:0]  o_reg_waddr,
  output logic [31:0] o_reg_wdata,
  output logic        o_pending_valid,
  output logic [4:0]  o_pending_rd,
  output logic        o_load_timeout
`ifdef WB_RETIRE_COUNT_EN
  ,
  output logic [63:0] o_retire_count
`endif
);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  localparam logic [15:0] LAST_COUNT = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_next;
  logic [15:0] count, count_next;
  logic [4:0]  lat_rd;
  logic        lat_rd_we;
  logic [2:0]  lat_funct3;
  logic [1:0]  lat_addr_lo;

  logic        transfer;
  logic        capture;
  logic        complete;
  logic        timeout;
  logic [4:0]  sel_rd;
  logic        sel_we;
  logic [31:0] sel_data;
  logic        do_write;

  // Unknown funct3 encodings fall through to a full-word load.
  function automatic logic [31:0] format_load(input logic [2:0] funct3,
                                              input logic [1:0] addr_lo,
                                              input logic [31:0] data);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] result;
    byte_sel = data[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? data[31:16] : data[15:0];
    case (funct3)
      3'b000:  result = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  result = {{16{half_sel[15]}}, half_sel};
      3'b100:  result = {24'h0, byte_sel};
      3'b101:  result = {16'h0, half_sel};
      default: result = data;
    endcase
    return result;
  endfunction

  assign o_ready         = (state == IDLE) && !i_reset;
  assign transfer        = i_valid && o_ready;
  assign o_pending_valid = (state == WAIT_MEM);
  assign o_pending_rd    = lat_rd;
  assign do_write        = complete && sel_we && (sel_rd != 5'd0);

  always_comb begin
    state_next = state;
    count_next = count;
    capture    = 1'b0;
    complete   = 1'b0;
    timeout    = 1'b0;
    sel_rd     = i_rd;
    sel_we     = i_rd_we;
    sel_data   = i_alu_result;
    case (state)
      IDLE: begin
        if (transfer) begin
          if (!i_is_load) begin
            complete = 1'b1;
          end else if (i_mem_rvalid) begin
            complete = 1'b1;
            sel_data = format_load(i_funct3, i_addr_lo, i_mem_rdata);
          end else begin
            capture    = 1'b1;
            state_next = WAIT_MEM;
            count_next = '0;
          end
        end
      end
      WAIT_MEM: begin
        sel_rd   = lat_rd;
        sel_we   = lat_rd_we;
        sel_data = format_load(lat_funct3, lat_addr_lo, i_mem_rdata);
        if (i_mem_rvalid) begin
          complete   = 1'b1;
          state_next = IDLE;
          count_next = '0;
        end else if (count == LAST_COUNT) begin
          timeout    = 1'b1;
          state_next = IDLE;
          count_next = '0;
        end else begin
          count_next = count + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Write address/data only move on a real write so they hold otherwise.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state          <= IDLE;
      count          <= '0;
      lat_rd         <= '0;
      lat_rd_we      <= 1'b0;
      lat_funct3     <= '0;
      lat_addr_lo    <= '0;
      o_reg_we       <= 1'b0;
      o_reg_waddr    <= '0;
      o_reg_wdata    <= '0;
      o_load_timeout <= 1'b0;
    end else begin
      state          <= state_next;
      count          <= count_next;
      o_reg_we       <= do_write;
      o_load_timeout <= timeout;
      if (capture) begin
        lat_rd      <= i_rd;
        lat_rd_we   <= i_rd_we;
        lat_funct3  <= i_funct3;
        lat_addr_lo <= i_addr_lo;
      end
      if (do_write) begin
        o_reg_waddr <= sel_rd;
        o_reg_wdata <= sel_data;
      end
    end
  end

`ifdef WB_RETIRE_COUNT_EN
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_retire_count <= '0;
    end else if (complete) begin
      o_retire_count <= o_retire_count + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard testbench for wb_stage: the driver pushes expected per-cycle writeback events,
// and a negedge monitor pops and compares them against the DUT outputs.
module tb_wb_stage;

  localparam int TO = 4;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid;
  logic        ready;
  logic [4:0]  rd;
  logic        rd_we;
  logic        is_load;
  logic [2:0]  funct3;
  logic [1:0]  addr_lo;
  logic [31:0] alu_result;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        reg_we;
  logic [4:0]  reg_waddr;
  logic [31:0] reg_wdata;
  logic        pending_valid;
  logic [4:0]  pending_rd;
  logic        load_timeout;
`ifdef WB_RETIRE_COUNT_EN
  logic [63:0] retire_count;
`endif

  wb_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clock        (clock),
    .i_reset        (reset),
    .i_valid        (valid),
    .o_ready        (ready),
    .i_rd           (rd),
    .i_rd_we        (rd_we),
    .i_is_load      (is_load),
    .i_funct3       (funct3),
    .i_addr_lo      (addr_lo),
    .i_alu_result   (alu_result),
    .i_mem_rdata    (mem_rdata),
    .i_mem_rvalid   (mem_rvalid),
    .o_reg_we       (reg_we),
    .o_reg_waddr    (reg_waddr),
    .o_reg_wdata    (reg_wdata),
    .o_pending_valid(pending_valid),
    .o_pending_rd   (pending_rd),
    .o_load_timeout (load_timeout)
`ifdef WB_RETIRE_COUNT_EN
    ,
    .o_retire_count (retire_count)
`endif
  );

  always #5 clock = ~clock;

  // One scoreboard entry per expected event: a completed instruction or an abandoned load.
  typedef struct {
    int          cyc;
    bit          is_to;
    bit          we;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;
  bit          mon_en = 1'b0;
  logic [4:0]  last_addr = '0;
  logic [31:0] last_data = '0;
  logic [63:0] exp_retire = '0;

  always @(posedge clock) cyc++;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference load formatting from the memory-byte view of the word.
  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] d);
    longint word;
    longint v;
    int     byte_idx;
    int     half_idx;
    word     = longint'(d);
    byte_idx = int'(a);
    half_idx = int'(a) / 2;
    case (f3)
      3'd0: begin v = (word >> (8 * byte_idx)) % 256;    if (v >= 128)   v = v - 256;   end
      3'd1: begin v = (word >> (16 * half_idx)) % 65536; if (v >= 32768) v = v - 65536; end
      3'd4: v = (word >> (8 * byte_idx)) % 256;
      3'd5: v = (word >> (16 * half_idx)) % 65536;
      default: v = word;
    endcase
    return 32'(v);
  endfunction

  function automatic void push_done(input logic [4:0] r, input logic w, input logic [31:0] data, input int at);
    exp_t e;
    e.cyc = at; e.is_to = 1'b0; e.we = w && (r != 5'd0); e.rd = r; e.data = data;
    sb.push_back(e);
  endfunction

  function automatic void push_timeout(input int at);
    exp_t e;
    e.cyc = at; e.is_to = 1'b1; e.we = 1'b0; e.rd = '0; e.data = '0;
    sb.push_back(e);
  endfunction

  always @(negedge clock) begin
    if (mon_en) begin
      logic        exp_we;
      logic        exp_to;
      logic [4:0]  exp_addr;
      logic [31:0] exp_data;
      exp_t        e;
      exp_we   = 1'b0;
      exp_to   = 1'b0;
      exp_addr = last_addr;
      exp_data = last_data;
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        checkOutput("stale_entry_cycle", 64'(cyc), 64'(e.cyc));
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        if (e.is_to) begin
          exp_to = 1'b1;
        end else begin
          exp_retire = exp_retire + 64'd1;
          if (e.we) begin
            exp_we   = 1'b1;
            exp_addr = e.rd;
            exp_data = e.data;
          end
        end
      end
      checkOutput("reg_we", 64'(reg_we), 64'(exp_we));
      checkOutput("load_timeout", 64'(load_timeout), 64'(exp_to));
      checkOutput("reg_waddr", 64'(reg_waddr), 64'(exp_addr));
      checkOutput("reg_wdata", 64'(reg_wdata), 64'(exp_data));
`ifdef WB_RETIRE_COUNT_EN
      checkOutput("retire_count", retire_count, exp_retire);
`endif
      last_addr = exp_addr;
      last_data = exp_data;
    end
  end

  task automatic applyStimulus(input logic v, input logic [4:0] r, input logic w, input logic ld,
                               input logic [2:0] f3, input logic [1:0] a, input logic [31:0] alu,
                               input logic [31:0] rdata, input logic rv);
    valid = v; rd = r; rd_we = w; is_load = ld; funct3 = f3; addr_lo = a;
    alu_result = alu; mem_rdata = rdata; mem_rvalid = rv;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue one instruction; for loads, rvalid arrives d cycles after transfer (d > TO abandons it).
  task automatic run_instr(input logic [4:0] r, input logic w, input logic ld, input logic [2:0] f3,
                           input logic [1:0] a, input logic [31:0] alu, input logic [31:0] rdata, input int d);
    logic [31:0] result;
    bit          hit;
    result = ld ? ref_load(f3, a, rdata) : alu;
    applyStimulus(1'b1, r, w, ld, f3, a, alu, (ld && d > 0) ? $urandom : rdata, ld && d == 0);
    if (!ld || d == 0) push_done(r, w, result, cyc + 1);
    @(negedge clock);
    checkOutput("ready_idle", 64'(ready), 64'd1);
    tick();
    if (ld && d > 0) begin
      for (int k = 1; k <= TO; k++) begin
        hit = (k == d);
        applyStimulus(1'b0, 5'($urandom), 1'b1, 1'b0, 3'($urandom), 2'($urandom), $urandom,
                      hit ? rdata : $urandom, hit);
        if (hit) push_done(r, w, result, cyc + 1);
        else if (k == TO) push_timeout(cyc + 1);
        @(negedge clock);
        checkOutput("ready_wait", 64'(ready), 64'd0);
        checkOutput("pending_valid", 64'(pending_valid), 64'd1);
        checkOutput("pending_rd", 64'(pending_rd), 64'(r));
        tick();
        if (hit) break;
      end
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
  endtask

  // Idle cycles with stray rvalid that the stage must ignore.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, 5'($urandom), 1'b1, 1'($urandom), 3'($urandom), 2'($urandom), $urandom,
                    $urandom, 1'($urandom));
      tick();
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
  endtask

  task automatic check_reset_values();
    checkOutput("rst_reg_we", 64'(reg_we), 64'd0);
    checkOutput("rst_waddr", 64'(reg_waddr), 64'd0);
    checkOutput("rst_wdata", 64'(reg_wdata), 64'd0);
    checkOutput("rst_pending_valid", 64'(pending_valid), 64'd0);
    checkOutput("rst_pending_rd", 64'(pending_rd), 64'd0);
    checkOutput("rst_load_timeout", 64'(load_timeout), 64'd0);
    checkOutput("rst_ready", 64'(ready), 64'd1);
`ifdef WB_RETIRE_COUNT_EN
    checkOutput("rst_retire_count", retire_count, 64'd0);
`endif
  endtask

  initial begin
    int d;
    reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("ready_in_reset", 64'(ready), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check_reset_values();
    mon_en = 1'b1;
    tick();

    $display("[TB] directed: ALU writes");
    run_instr(5'd5, 1'b1, 1'b0, 3'd0, 2'd0, 32'hDEADBEEF, '0, 0);
    idle_cycles(1);
    run_instr(5'd1, 1'b1, 1'b0, 3'd0, 2'd0, 32'h11, '0, 0);
    run_instr(5'd2, 1'b1, 1'b0, 3'd0, 2'd0, 32'h22, '0, 0);
    run_instr(5'd0, 1'b1, 1'b0, 3'd0, 2'd0, 32'h33, '0, 0);
    idle_cycles(2);

    $display("[TB] directed: loads");
    run_instr(5'd7, 1'b1, 1'b1, 3'b000, 2'd3, '0, 32'h80FF_1234, 4);
    run_instr(5'd8, 1'b1, 1'b1, 3'b100, 2'd3, '0, 32'h80FF_1234, 4);
    run_instr(5'd9, 1'b1, 1'b1, 3'b001, 2'd2, '0, 32'h8001_7FFF, 0);
    run_instr(5'd10, 1'b1, 1'b1, 3'b101, 2'd0, '0, 32'h8001_7FFF, 0);
    run_instr(5'd11, 1'b1, 1'b1, 3'b010, 2'd0, '0, 32'h0, TO + 1);
    idle_cycles(2);

    $display("[TB] directed: reset during WAIT_MEM");
    applyStimulus(1'b1, 5'd12, 1'b1, 1'b1, 3'b010, 2'd0, '0, '0, 1'b0);
    tick();
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
    tick();
    mon_en = 1'b0;
    reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, 32'hCAFE_F00D, 1'b1);
    @(negedge clock);
    checkOutput("ready_reset_dominates", 64'(ready), 64'd0);
    tick();
    reset = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
    last_addr = '0;
    last_data = '0;
    exp_retire = '0;
    @(negedge clock);
    check_reset_values();
    checkOutput("sb_empty_after_reset", 64'(sb.size()), 64'd0);
    mon_en = 1'b1;
    tick();
    run_instr(5'd13, 1'b1, 1'b0, 3'd0, 2'd0, 32'h1234_5678, '0, 0);
    idle_cycles(1);

    $display("[TB] random stimulus");
    for (int n = 0; n < 300; n++) begin
      d = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, TO + 2));
      run_instr(5'($urandom), 1'($urandom_range(0, 4) != 0), 1'($urandom), 3'($urandom), 2'($urandom),
                $urandom, $urandom, d);
      if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 3)));
    end

    idle_cycles(3);
    checkOutput("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
